// File: rtl/int_regfile_mp.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// Reads are combinational with optional write bypass; writes and busy updates happen on the rising edge.
module int_regfile_mp #(
    parameter int XLEN     = 32,
    parameter int INDEX    = 5,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int NREGS   = 2**INDEX
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [NREAD*INDEX-1:0]   RA,
    output logic [NREAD*XLEN-1:0]    RD,
    output logic [NREAD-1:0]         RBUSY,
    input  logic [NWRITE-1:0]        WE,
    input  logic [NWRITE*INDEX-1:0]  WA,
    input  logic [NWRITE*XLEN-1:0]   WD,
    input  logic                     ISSUE_EN,
    input  logic [INDEX-1:0]         ISSUE_RD,
    output logic [NREGS-1:0]         BUSY_VEC
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             hit_s;
    logic             clr_s;
    logic             set_s;
    logic [INDEX-1:0] ra_s;
    logic [XLEN-1:0]  rdat_s;

    function automatic logic is_zero_addr(input logic [INDEX-1:0] addr);
        return (ZERO_REG != 0) && (addr == {INDEX{1'b0}});
    endfunction

    // Next-state for the register array and the pending-write scoreboard
    always_comb begin
        clr_s = 1'b0;
        hit_s = 1'b0;
        set_s = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            clr_s     = 1'b0;
            // Later ports override earlier ones, so the highest-index writer wins
            for (int p = 0; p < NWRITE; p++) begin
                hit_s     = WE[p] && (WA[p*INDEX +: INDEX] == INDEX'(i));
                regs_d[i] = (hit_s && !is_zero_addr(INDEX'(i))) ? WD[p*XLEN +: XLEN] : regs_d[i];
                clr_s     = clr_s | hit_s;
            end
            set_s     = ISSUE_EN && (ISSUE_RD == INDEX'(i)) && !is_zero_addr(INDEX'(i));
            busy_d[i] = set_s ? 1'b1 : (clr_s ? 1'b0 : busy_q[i]);
        end
    end

    // Read ports: stored value, optional same-cycle bypass, zero register and reset override
    always_comb begin
        RD     = {(NREAD*XLEN){1'b0}};
        RBUSY  = {NREAD{1'b0}};
        ra_s   = {INDEX{1'b0}};
        rdat_s = {XLEN{1'b0}};
        for (int r = 0; r < NREAD; r++) begin
            ra_s   = RA[r*INDEX +: INDEX];
            rdat_s = regs_q[ra_s];
            for (int p = 0; p < NWRITE; p++) begin
                rdat_s = ((BYPASS != 0) && WE[p] && (WA[p*INDEX +: INDEX] == ra_s)) ?
                         WD[p*XLEN +: XLEN] : rdat_s;
            end
            // Reset must also silence bypassed write data
            RD[r*XLEN +: XLEN] = (is_zero_addr(ra_s) || !RST_N) ? {XLEN{1'b0}} : rdat_s;
            RBUSY[r]           = is_zero_addr(ra_s) ? 1'b0 : busy_q[ra_s];
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
            busy_q <= {NREGS{1'b0}};
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign BUSY_VEC = busy_q;

endmodule

// File: tb/tb_int_regfile_mp.sv
// Bench for int_regfile_mp: a dual-write/bypass/zero-reg instance (A) and a
// single-write/no-bypass/ordinary-x0 instance (B), checked through an expected-value queue.
module tb_int_regfile_mp;

    logic        CLK = 1'b0;
    logic        RST_N;

    logic [9:0]  a_ra;
    logic [63:0] a_rd;
    logic [1:0]  a_rbusy;
    logic [1:0]  a_we;
    logic [9:0]  a_wa;
    logic [63:0] a_wd;
    logic        a_iss_en;
    logic [4:0]  a_iss_rd;
    logic [31:0] a_busy;

    logic [9:0]  b_ra;
    logic [63:0] b_rd;
    logic [1:0]  b_rbusy;
    logic [0:0]  b_we;
    logic [4:0]  b_wa;
    logic [31:0] b_wd;
    logic        b_iss_en;
    logic [4:0]  b_iss_rd;
    logic [31:0] b_busy;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic [31:0] mdl [32];

    always #5 CLK = ~CLK;

    int_regfile_mp #(.XLEN(32), .INDEX(5), .NREAD(2), .NWRITE(2), .ZERO_REG(1), .BYPASS(1)) u_a (
        .CLK(CLK), .RST_N(RST_N), .RA(a_ra), .RD(a_rd), .RBUSY(a_rbusy),
        .WE(a_we), .WA(a_wa), .WD(a_wd), .ISSUE_EN(a_iss_en), .ISSUE_RD(a_iss_rd),
        .BUSY_VEC(a_busy)
    );

    int_regfile_mp #(.XLEN(32), .INDEX(5), .NREAD(2), .NWRITE(1), .ZERO_REG(0), .BYPASS(0)) u_b (
        .CLK(CLK), .RST_N(RST_N), .RA(b_ra), .RD(b_rd), .RBUSY(b_rbusy),
        .WE(b_we), .WA(b_wa), .WD(b_wd), .ISSUE_EN(b_iss_en), .ISSUE_RD(b_iss_rd),
        .BUSY_VEC(b_busy)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        a_we     = 2'b00;
        a_iss_en = 1'b0;
        b_we     = 1'b0;
        b_iss_en = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        a_we = 2'b01; a_wa = {5'd0, 5'd5}; a_wd = {32'h0, 32'hDEAD_BEEF};
        a_ra = {5'd5, 5'd5}; a_iss_en = 1'b1; a_iss_rd = 5'd5;
        b_we = 1'b1; b_wa = 5'd5; b_wd = 32'hDEAD_BEEF; b_ra = {5'd5, 5'd5};
        b_iss_en = 1'b1; b_iss_rd = 5'd5;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        @(posedge CLK);
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== exp_v) begin errors++; $display("FAIL reset_hold_rd_a: got %h want %h", a_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (b_rd[31:0] !== exp_v) begin errors++; $display("FAIL reset_hold_rd_b: got %h want %h", b_rd[31:0], exp_v); end
        RST_N = 1'b1;
        idle();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== exp_v) begin errors++; $display("FAIL reset_discard_rd: got %h want %h", a_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (a_busy !== exp_v) begin errors++; $display("FAIL reset_busy_a: got %h want %h", a_busy, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (b_busy !== exp_v) begin errors++; $display("FAIL reset_busy_b: got %h want %h", b_busy, exp_v); end
        a_we = 2'b01; a_wa = {5'd0, 5'd5}; a_wd = {32'h0, 32'hCAFE_0005};
        exp_q.push_back(32'hCAFE_0005);
        tick();
        idle();
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== exp_v) begin errors++; $display("FAIL written_x5: got %h want %h", a_rd[31:0], exp_v); end
        exp_q.push_back(32'h0);
        #1 RST_N = 1'b0;
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== exp_v) begin errors++; $display("FAIL async_reset_rd: got %h want %h", a_rd[31:0], exp_v); end
        #1 RST_N = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    endtask

    task automatic test_zero_reg();
        tick();
        a_we = 2'b01; a_wa = 10'd0; a_wd = {32'h0, 32'h1234_5678};
        a_iss_en = 1'b1; a_iss_rd = 5'd0; a_ra = 10'd0;
        b_we = 1'b1; b_wa = 5'd0; b_wd = 32'h1234_5678;
        b_iss_en = 1'b1; b_iss_rd = 5'd0; b_ra = 10'd0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== exp_v) begin errors++; $display("FAIL zero_bypass_a: got %h want %h", a_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (b_rd[31:0] !== exp_v) begin errors++; $display("FAIL x0_old_b: got %h want %h", b_rd[31:0], exp_v); end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h1);
        tick();
        idle();
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== exp_v) begin errors++; $display("FAIL zero_rd_a: got %h want %h", a_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, a_busy[0]} !== exp_v) begin errors++; $display("FAIL zero_busy_a: got %h want %h", a_busy[0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (b_rd[31:0] !== exp_v) begin errors++; $display("FAIL x0_written_b: got %h want %h", b_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, b_rbusy[0]} !== exp_v) begin errors++; $display("FAIL x0_rbusy_b: got %h want %h", b_rbusy[0], exp_v); end
        b_we = 1'b1; b_wa = 5'd0; b_wd = 32'h1234_5678;
        exp_q.push_back(32'h0);
        tick();
        idle();
        exp_v = exp_q.pop_front(); checks++;
        if (b_busy !== exp_v) begin errors++; $display("FAIL x0_clear_b: got %h want %h", b_busy, exp_v); end
    endtask

    task automatic test_bypass();
        tick();
        a_we = 2'b01; a_wa = {5'd0, 5'd7}; a_wd = {32'h0, 32'h0000_0777};
        b_we = 1'b1; b_wa = 5'd7; b_wd = 32'h0000_0777;
        tick();
        a_wd = {32'h0, 32'hA5A5_0001}; a_ra = {5'd0, 5'd7};
        b_wd = 32'hA5A5_0001; b_ra = {5'd0, 5'd7};
        exp_q.push_back(32'hA5A5_0001);
        exp_q.push_back(32'h0000_0777);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== exp_v) begin errors++; $display("FAIL bypass_a: got %h want %h", a_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (b_rd[31:0] !== exp_v) begin errors++; $display("FAIL nobypass_old_b: got %h want %h", b_rd[31:0], exp_v); end
        exp_q.push_back(32'hA5A5_0001);
        exp_q.push_back(32'hA5A5_0001);
        tick();
        idle();
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== exp_v) begin errors++; $display("FAIL stored_a: got %h want %h", a_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (b_rd[31:0] !== exp_v) begin errors++; $display("FAIL nobypass_new_b: got %h want %h", b_rd[31:0], exp_v); end
        mdl[7] = 32'hA5A5_0001;
    endtask

    task automatic test_dual_write();
        tick();
        a_we = 2'b11; a_wa = {5'd9, 5'd9}; a_wd = {32'h2222_2222, 32'h1111_1111};
        a_ra = {5'd9, 5'd9};
        exp_q.push_back(32'h2222_2222);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== exp_v) begin errors++; $display("FAIL dual_bypass: got %h want %h", a_rd[31:0], exp_v); end
        exp_q.push_back(32'h2222_2222);
        exp_q.push_back(32'h2222_2222);
        tick();
        idle();
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== exp_v) begin errors++; $display("FAIL dual_rd0: got %h want %h", a_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (a_rd[63:32] !== exp_v) begin errors++; $display("FAIL dual_rd1: got %h want %h", a_rd[63:32], exp_v); end
        mdl[9] = 32'h2222_2222;
    endtask

    task automatic test_scoreboard();
        tick();
        a_iss_en = 1'b1; a_iss_rd = 5'd12; a_ra = {5'd0, 5'd12};
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, a_rbusy[0]} !== exp_v) begin errors++; $display("FAIL sb_cycle0: got %h want %h", a_rbusy[0], exp_v); end
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0000_1000);
        tick();
        a_iss_en = 1'b0;
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, a_rbusy[0]} !== exp_v) begin errors++; $display("FAIL sb_cycle1: got %h want %h", a_rbusy[0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (a_busy !== exp_v) begin errors++; $display("FAIL sb_vec1: got %h want %h", a_busy, exp_v); end
        exp_q.push_back(32'h1);
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, a_rbusy[0]} !== exp_v) begin errors++; $display("FAIL sb_cycle2: got %h want %h", a_rbusy[0], exp_v); end
        tick();
        a_we = 2'b01; a_wa = {5'd0, 5'd12}; a_wd = {32'h0, 32'h0000_00C3};
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0000_00C3);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, a_rbusy[0]} !== exp_v) begin errors++; $display("FAIL sb_cycle3_busy: got %h want %h", a_rbusy[0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== exp_v) begin errors++; $display("FAIL sb_cycle3_rd: got %h want %h", a_rd[31:0], exp_v); end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        tick();
        idle();
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, a_rbusy[0]} !== exp_v) begin errors++; $display("FAIL sb_cycle4: got %h want %h", a_rbusy[0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (a_busy !== exp_v) begin errors++; $display("FAIL sb_vec4: got %h want %h", a_busy, exp_v); end
        mdl[12] = 32'h0000_00C3;
    endtask

    task automatic test_collision();
        tick();
        a_iss_en = 1'b1; a_iss_rd = 5'd12; a_ra = {5'd0, 5'd12};
        tick();
        a_we = 2'b01; a_wa = {5'd0, 5'd12}; a_wd = {32'h0, 32'h0000_0042};
        exp_q.push_back(32'h0000_0042);
        exp_q.push_back(32'h1);
        tick();
        idle();
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (a_rd[31:0] !== exp_v) begin errors++; $display("FAIL collide_rd: got %h want %h", a_rd[31:0], exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, a_busy[12]} !== exp_v) begin errors++; $display("FAIL collide_busy: got %h want %h", a_busy[12], exp_v); end
        a_we = 2'b01;
        exp_q.push_back(32'h0);
        tick();
        idle();
        exp_v = exp_q.pop_front(); checks++;
        if (a_busy !== exp_v) begin errors++; $display("FAIL collide_release: got %h want %h", a_busy, exp_v); end
        mdl[12] = 32'h0000_0042;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  wa0, wa1, prev0, prev1;
        logic [31:0] wd0, wd1, e0, e1;
        logic [1:0]  we;
        prev0 = 5'd7;
        prev1 = 5'd9;
        tick();
        for (int it = 0; it < 24; it++) begin
            wa0 = 5'($urandom_range(0, 31));
            wa1 = (it % 4 == 0) ? wa0 : 5'($urandom_range(0, 31));
            wd0 = $urandom;
            wd1 = $urandom;
            we  = 2'($urandom_range(1, 3));
            e0 = mdl[prev0];
            if (we[0] && wa0 == prev0) e0 = wd0;
            if (we[1] && wa1 == prev0) e0 = wd1;
            if (prev0 == 5'd0) e0 = 32'h0;
            e1 = mdl[prev1];
            if (we[0] && wa0 == prev1) e1 = wd0;
            if (we[1] && wa1 == prev1) e1 = wd1;
            if (prev1 == 5'd0) e1 = 32'h0;
            exp_q.push_back(e0);
            exp_q.push_back(e1);
            a_we = we; a_wa = {wa1, wa0}; a_wd = {wd1, wd0}; a_ra = {prev1, prev0};
            #1;
            exp_v = exp_q.pop_front(); checks++;
            if (a_rd[31:0] !== exp_v) begin errors++; $display("FAIL b2b_rd0 it=%0d: got %h want %h", it, a_rd[31:0], exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (a_rd[63:32] !== exp_v) begin errors++; $display("FAIL b2b_rd1 it=%0d: got %h want %h", it, a_rd[63:32], exp_v); end
            if (we[0] && wa0 != 5'd0) mdl[wa0] = wd0;
            if (we[1] && wa1 != 5'd0) mdl[wa1] = wd1;
            prev0 = wa0;
            prev1 = wa1;
            tick();
        end
        idle();
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (a_busy !== exp_v) begin errors++; $display("FAIL b2b_busy: got %h want %h", a_busy, exp_v); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        a_ra = 10'd0; a_we = 2'b00; a_wa = 10'd0; a_wd = 64'd0; a_iss_en = 1'b0; a_iss_rd = 5'd0;
        b_ra = 10'd0; b_we = 1'b0; b_wa = 5'd0; b_wd = 32'd0; b_iss_en = 1'b0; b_iss_rd = 5'd0;
        test_reset();
        test_zero_reg();
        test_bypass();
        test_dual_write();
        test_scoreboard();
        test_collision();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_regfile_mp.md
Name: int_regfile_mp

Overview:
- Parametrised multi-port integer register file with a per-register pending-write scoreboard, for the RV32I/M integer datapath.
- Provides NREAD combinational read ports and NWRITE synchronous write ports.
- Optional write-to-read bypass; optional hardwired-zero x0.
- Busy bits let decode stall on registers whose producing instruction has issued but not yet written back.

Parameters:
- XLEN, 32, data width of each register.
- INDEX, 5, address width; register count NREGS = 2**INDEX.
- NREAD, 2, number of read ports (1..4).
- NWRITE, 1, number of write ports (1..2).
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/issues; 0 = register 0 is ordinary.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- RA  in  NREAD*INDEX  read addresses; port r uses bits [r*INDEX +: INDEX].
- RD  out  NREAD*XLEN  read data; port r at [r*XLEN +: XLEN].
- RBUSY  out  NREAD  busy bit of the register addressed by each read port.
- WE  in  NWRITE  write enables.
- WA  in  NWRITE*INDEX  write addresses.
- WD  in  NWRITE*XLEN  write data.
- ISSUE_EN  in  1  mark destination pending.
- ISSUE_RD  in  INDEX  destination register being issued.
- BUSY_VEC  out  NREGS  full scoreboard, bit i = register i pending.

Behaviour:
- Reset: RST_N low asynchronously clears all registers to 0 and all busy bits to 0.
  - Outputs during and after reset: RD = 0, RBUSY = 0, BUSY_VEC = 0.
  - Reset asserted mid-operation discards any write or issue in that cycle.
- Read: combinational, zero latency. RD[r] = register[RA[r]] unless overridden:
  - ZERO_REG = 1 and RA[r] == 0: RD[r] = 0 and RBUSY[r] = 0.
  - BYPASS = 1 and some enabled write port p has WA[p] == RA[r] (and the address is not a hardwired zero): RD[r] = WD[p] of the highest-index matching port.
  - BYPASS = 0: RD[r] shows the old value until the edge after the write.
- Write: on the rising CLK edge, for each p with WE[p] = 1, register[WA[p]] <= WD[p].
  - ZERO_REG = 1: writes to address 0 are dropped.
  - Two ports writing the same address in one cycle: the higher-index port wins.
- Scoreboard update per rising edge, per register i:
  - set = ISSUE_EN && ISSUE_RD == i && !(ZERO_REG && i == 0).
  - clr = any WE[p] && WA[p] == i.
  - Next busy[i] = set ? 1 : (clr ? 0 : busy[i]).
  - Set has priority over clear: a new producer issued in the same cycle as an older producer's writeback leaves the register busy.
  - A write to a non-busy register is legal and leaves busy at 0.
- RBUSY[r] = busy[RA[r]], taken from the registered scoreboard.
  - It is not bypassed by a same-cycle clear. Decode sees busy drop one cycle after writeback, and the read data arrives through BYPASS in the writeback cycle.
- BUSY_VEC equals the registered busy bits, with no combinational path from the inputs.
- Addresses are always in range (NREGS = 2**INDEX); there is no wrap or out-of-range case.
- Implementation: a register array plus an NREGS-bit busy vector. No state machine beyond the scoreboard.

Test Plan:
- Reset: hold RST_N=0 with WE=1, WA=5, WD=32'hDEAD_BEEF across a CLK edge, then release. Required: RD for RA=5 is 0 and BUSY_VEC = 0. Also assert RST_N=0 asynchronously between edges after x5 has been written: RD drops to 0 immediately.
- Zero register (ZERO_REG=1): write x0 = 32'h1234_5678 and issue rd=0. Required: RD for RA=0 is 0 and BUSY_VEC[0] stays 0. Repeat with ZERO_REG=0: x0 reads 32'h1234_5678 next cycle.
- Bypass (BYPASS=1): RA0=7 with WE=1, WA=7, WD=32'hA5A5_0001 in the same cycle. Required: RD0 = 32'hA5A5_0001 before the edge. With BYPASS=0, RD0 shows the old value, then 32'hA5A5_0001 after the edge.
- Dual write (NWRITE=2): both ports write x9, port0 32'h1111_1111 and port1 32'h2222_2222. Required: x9 = 32'h2222_2222.
- Scoreboard lifecycle: issue rd=12 on cycle 0; RBUSY for RA=12 reads 1 from cycle 1; write x12 on cycle 3; RBUSY = 0 from cycle 4.
- Set/clear collision: x12 busy, then in one cycle ISSUE_EN with rd=12 and WE with WA=12, WD=32'h0000_0042. Required: x12 = 32'h0000_0042 and BUSY_VEC[12] = 1 after the edge.
